ro_freq_meter: RTL

Parametrised ring-oscillator bank controller and frequency counter for the Tiny Tapeout user tile. It enables one of `NUM_CH` on-die ring oscillators and synchronises that oscillator's output into `clk`. It then counts the oscillator's rising edges over a programmable gate window of `clk` cycles and holds the result for readout. It sits between the raw oscillator instances and the tile's `uo_out`/`uio` readout logic.

---
 rtl/ro_pkg.sv | 17 +
 rtl/ro_sync.sv | 35 +++
 rtl/ro_freq_meter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ro_pkg.sv
// ro_pkg: shared types and constants for the ring-oscillator frequency meter.
//   ro_state_t    - measurement FSM states
//   SETTLE_CYCLES - cycles spent filling the synchroniser and edge detector
//                   before any edge is counted
package ro_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } ro_state_t;

    localparam int SETTLE_CYCLES = 3;
    localparam int SETTLE_W      = $clog2(SETTLE_CYCLES);

endpackage

// File: rtl/ro_sync.sv
// ro_sync: two-flop synchroniser that brings the selected (asynchronous)
// oscillator output into the clk domain. Both flops reset to 0.
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   d   - asynchronous input
//   q   - synchronised output, two cycles behind d
module ro_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: ring-oscillator bank controller and frequency counter.
// Enables one of NUM_CH oscillators, synchronises its output into clk and
// counts rising edges over a window of gate_cycles clk cycles.
// Optional feature macro: RO_FREQ_CONTINUOUS_EN adds the 'cont' input, which
// makes the meter re-measure back to back with the latched settings.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - request a measurement (accepted in IDLE only)
//   ch_sel       - channel to measure, clamped to NUM_CH-1, latched on start
//   gate_cycles  - window length in clk cycles, latched on start
//   osc_in       - raw oscillator outputs (asynchronous)
//   cont         - (RO_FREQ_CONTINUOUS_EN only) keep measuring after DONE
//   osc_en       - one-hot oscillator enable, zero when not measuring
//   busy         - measurement in progress (SETTLE or MEASURE)
//   done         - one-cycle pulse, count/overflow valid
//   count        - edges counted in the last window (saturating)
//   overflow     - last window saturated the counter
module ro_freq_meter
    import ro_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 16,
    parameter int  GATE_W = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [NUM_CH-1:0] osc_in,
`ifdef RO_FREQ_CONTINUOUS_EN
    input  logic              cont,
`endif
    output logic [NUM_CH-1:0] osc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] sel);
        logic [31:0] wide;
        wide = 32'(sel);
        if (wide >= 32'(NUM_CH)) return CH_W'(NUM_CH - 1);
        return sel;
    endfunction

    // Returns {overflow, count} after an optional saturating increment.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             ovf,
                                               input logic             hit);
        if (!hit) return {ovf, c};
        if (&c)   return {1'b1, c};
        return {ovf, c + CNT_W'(1)};
    endfunction

    // Control and output registers (reset)
    ro_state_t          state_q, state_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    // Data registers (loaded on start, no reset needed)
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               chan_raw;
    logic               chan_sync;
    logic               rise;
    logic [CNT_W:0]     acc;

    // Stage 0: channel mux ahead of the synchroniser
    assign chan_raw = osc_in[ch_q];

    ro_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (chan_raw),
        .q   (chan_sync)
    );

    // Stage 1: edge detect on the synchronised channel
    assign rise = chan_sync & ~prev_q;
    assign acc  = sat_inc(cnt_q, ovf_q, rise && (state_q == MEASURE));

    always_comb begin
        state_d    = state_q;
        prev_d     = chan_sync;
        count_d    = count_q;
        overflow_d = overflow_q;
        ch_d       = ch_q;
        gate_d     = gate_q;
        gate_cnt_d = gate_cnt_q;
        settle_d   = settle_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d     = clamp_ch(ch_sel);
                    gate_d   = gate_cycles;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    gate_cnt_d = '0;
                    if (gate_q == '0) begin
                        // Empty window: result is the freshly cleared counter.
                        count_d    = cnt_q;
                        overflow_d = ovf_q;
                        state_d    = DONE;
                    end else begin
                        state_d = MEASURE;
                    end
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            MEASURE: begin
                cnt_d      = acc[CNT_W-1:0];
                ovf_d      = acc[CNT_W];
                gate_cnt_d = gate_cnt_q + GATE_W'(1);
                if (gate_cnt_q == gate_q - GATE_W'(1)) begin
                    // Publish on entry to DONE so the result (including an
                    // edge in the last window cycle) is visible with done.
                    count_d    = acc[CNT_W-1:0];
                    overflow_d = acc[CNT_W];
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef RO_FREQ_CONTINUOUS_EN
                if (cont) begin
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        ch_q       <= ch_d;
        gate_q     <= gate_d;
        gate_cnt_q <= gate_cnt_d;
        settle_q   <= settle_d;
        cnt_q      <= cnt_d;
        ovf_q      <= ovf_d;
    end

    always_comb begin
        osc_en = '0;
        if (state_q == SETTLE || state_q == MEASURE) osc_en[ch_q] = 1'b1;
    end

    assign busy     = (state_q == SETTLE) || (state_q == MEASURE);
    assign done     = (state_q == DONE);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
